// File: rtl/t8086_pkg.sv
// Shared definitions for the 8086-style front end: address width, reset vector
// and the prefetch fetch-control state encoding.
package t8086_pkg;

    localparam int          ADDR_W   = 20;
    localparam logic [15:0] RESET_CS = 16'hFFFF;
    localparam logic [15:0] RESET_IP = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    // Real-mode physical address; the carry out of bit 19 is dropped.
    function automatic logic [ADDR_W-1:0] phys_addr(input logic [15:0] cs, input logic [15:0] ip);
        return {cs, 4'b0000} + {4'b0000, ip};
    endfunction

endpackage

// File: rtl/prefetch_ring.sv
// Circular byte buffer with multi-byte push at the tail and multi-byte pop at the head.
// The caller guarantees pops never exceed count and pushes never overflow.
module prefetch_ring #(
    parameter int DEPTH       = 6,
    parameter int FETCH_BYTES = 1,
    parameter int PEEK        = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic [8*FETCH_BYTES-1:0]     push_data,
    input  logic [2:0]                   pop_n,
    output logic [8*PEEK-1:0]            peek,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    // DEPTH need not be a power of two, so wrap explicitly; off is always < DEPTH... or < 2*DEPTH - base.
    function automatic logic [PW-1:0] idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            for (int b = 0; b < FETCH_BYTES; b++)
                mem[idx(tail, b)] <= push_data[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= idx(tail, FETCH_BYTES);
            head  <= idx(head, int'(pop_n));
            count <= CW'(int'(count) - int'(pop_n) + (push ? FETCH_BYTES : 0));
        end
    end

    // Lanes beyond the valid bytes read as zero so the decoder never sees stale data.
    always_comb begin
        peek = '0;
        for (int p = 0; p < PEEK; p++) begin
            if (p < int'(count)) peek[8*p +: 8] = mem[idx(head, p)];
        end
    end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches code bytes from a one-cycle-latency ROM at
// CS:IP, presents the oldest PEEK bytes to the decoder and handles redirects.
module prefetch_queue
    import t8086_pkg::*;
#(
    parameter int DEPTH       = 6,
    parameter int FETCH_BYTES = 1,
    parameter int PEEK        = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         rom_en,
    output logic [19:0]                  rom_addr,
    input  logic [8*FETCH_BYTES-1:0]     rom_data,
    input  logic                         flush,
    input  logic [15:0]                  flush_cs,
    input  logic [15:0]                  flush_ip,
    output logic [8*PEEK-1:0]            q_data,
    output logic [$clog2(DEPTH+1)-1:0]   q_count,
    output logic [15:0]                  q_ip,
    input  logic [2:0]                   pop_cnt,
    output logic                         pop_err,
    output logic [1:0]                   dbg_state
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] fetch_addr;
    logic              inflight;
    logic              pop_bad;
    logic              pop_ok;
    logic              push;
    logic              has_room;
    logic [2:0]        pop_n;
    int                room;

    // FETCH means a request went out last cycle, so its data is on rom_data now.
    assign inflight = (state == ST_FETCH);
    assign pop_bad  = (int'(pop_cnt) > int'(q_count)) || (int'(pop_cnt) > PEEK);
    assign pop_ok   = !pop_bad && !flush;
    assign pop_n    = pop_ok ? pop_cnt : 3'd0;
    assign push     = inflight && !flush;
    assign room     = DEPTH - int'(q_count) - (inflight ? FETCH_BYTES : 0);
    assign has_room = (room >= FETCH_BYTES);

    assign rom_en    = rst && has_room && !flush && !pop_bad;
    assign rom_addr  = fetch_addr;
    assign pop_err   = rst && pop_bad;
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        if (flush)       state_next = ST_DRAIN;
        else if (rom_en) state_next = ST_FETCH;
        else             state_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            fetch_addr <= phys_addr(RESET_CS, RESET_IP);
            q_ip       <= RESET_IP;
        end else begin
            state <= state_next;
            if (flush) begin
                fetch_addr <= phys_addr(flush_cs, flush_ip);
                q_ip       <= flush_ip;
            end else begin
                if (rom_en) fetch_addr <= fetch_addr + ADDR_W'(FETCH_BYTES);
                if (pop_ok) q_ip <= q_ip + 16'(pop_cnt);
            end
        end
    end

    prefetch_ring #(
        .DEPTH      (DEPTH),
        .FETCH_BYTES(FETCH_BYTES),
        .PEEK       (PEEK)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .push     (push),
        .push_data(rom_data),
        .pop_n    (pop_n),
        .peek     (q_data),
        .count    (q_count)
    );

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench: default-parameter queue (reset fill, pop, flush, illegal pop)
// and a DEPTH=8 / 2-byte-fetch queue (address wrap, IP wrap, full-queue pop+push).
module tb_prefetch_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        rom_en0;
    logic [19:0] rom_addr0;
    logic [7:0]  rom_data0;
    logic        flush0;
    logic [15:0] flush_cs0;
    logic [15:0] flush_ip0;
    logic [47:0] q_data0;
    logic [2:0]  q_count0;
    logic [15:0] q_ip0;
    logic [2:0]  pop_cnt0;
    logic        pop_err0;
    logic [1:0]  dbg0;

    logic        rom_en1;
    logic [19:0] rom_addr1;
    logic [15:0] rom_data1;
    logic        flush1;
    logic [15:0] flush_cs1;
    logic [15:0] flush_ip1;
    logic [47:0] q_data1;
    logic [3:0]  q_count1;
    logic [15:0] q_ip1;
    logic [2:0]  pop_cnt1;
    logic        pop_err1;
    logic [1:0]  dbg1;

    int n_tests = 0;
    int n_fail  = 0;

    prefetch_queue dut0 (
        .clk(clk), .rst(rst), .rom_en(rom_en0), .rom_addr(rom_addr0), .rom_data(rom_data0),
        .flush(flush0), .flush_cs(flush_cs0), .flush_ip(flush_ip0), .q_data(q_data0),
        .q_count(q_count0), .q_ip(q_ip0), .pop_cnt(pop_cnt0), .pop_err(pop_err0),
        .dbg_state(dbg0)
    );

    prefetch_queue #(.DEPTH(8), .FETCH_BYTES(2), .PEEK(6)) dut1 (
        .clk(clk), .rst(rst), .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_data(rom_data1),
        .flush(flush1), .flush_cs(flush_cs1), .flush_ip(flush_ip1), .q_data(q_data1),
        .q_count(q_count1), .q_ip(q_ip1), .pop_cnt(pop_cnt1), .pop_err(pop_err1),
        .dbg_state(dbg1)
    );

    // Reset vector holds EA 00 00 00 F0 F0; every other byte is addr[7:0] ^ 0x5A.
    function automatic logic [7:0] rom_byte(input logic [19:0] a);
        case (a)
            20'hFFFF0: return 8'hEA;
            20'hFFFF1: return 8'h00;
            20'hFFFF2: return 8'h00;
            20'hFFFF3: return 8'h00;
            20'hFFFF4: return 8'hF0;
            20'hFFFF5: return 8'hF0;
            default:   return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rom_en0) rom_data0 <= rom_byte(rom_addr0);
        if (rom_en1) rom_data1 <= {rom_byte(rom_addr1 + 20'd1), rom_byte(rom_addr1)};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        rom_data0 = '0; rom_data1 = '0;
        flush0 = 1'b0; flush_cs0 = '0; flush_ip0 = '0; pop_cnt0 = '0;
        flush1 = 1'b0; flush_cs1 = '0; flush_ip1 = '0; pop_cnt1 = '0;
        tick();
        tick();

        // reset state
        check("rst_count", q_count0, 0);
        check("rst_rom_en", rom_en0, 0);
        check("rst_pop_err", pop_err0, 0);
        check("rst_q_data", q_data0, 0);
        check("rst_q_ip", q_ip0, 16'h0000);
        check("rst_addr", rom_addr0, 20'hFFFF0);
        check("rst_state", dbg0, 0);

        // fill from the reset vector
        rst = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("fill_en_%0d", i), rom_en0, 1);
            check($sformatf("fill_addr_%0d", i), rom_addr0, 20'hFFFF0 + 20'(i));
            tick();
        end
        check("full_guard_en", rom_en0, 0);
        tick();
        check("full_count", q_count0, 6);
        check("full_en", rom_en0, 0);
        check("full_data", q_data0, 48'hF0F0000000EA);
        check("full_state", dbg0, 0);

        // legal pop of 3
        pop_cnt0 = 3'd3;
        #1;
        check("pop3_err", pop_err0, 0);
        tick();
        pop_cnt0 = 3'd0;
        #1;
        check("pop3_count", q_count0, 3);
        check("pop3_ip", q_ip0, 16'h0003);
        check("pop3_byte0", q_data0[7:0], 8'h00);
        check("pop3_data", q_data0, 48'h000000F0F000);
        check("pop3_refill_en", rom_en0, 1);
        check("pop3_refill_addr", rom_addr0, 20'hFFFF6);
        tick();

        // flush while the FFFF6 byte is returning
        flush0 = 1'b1; flush_cs0 = 16'h1000; flush_ip0 = 16'h0010;
        #1;
        check("flush_en_low", rom_en0, 0);
        tick();
        flush0 = 1'b0;
        #1;
        check("flush_count", q_count0, 0);
        check("flush_ip", q_ip0, 16'h0010);
        check("flush_state", dbg0, 2);
        check("flush_first_en", rom_en0, 1);
        check("flush_first_addr", rom_addr0, 20'h10010);
        check("flush_q_data", q_data0, 0);
        tick();
        check("stale_dropped", q_count0, 0);
        check("flush_second_addr", rom_addr0, 20'h10011);
        tick();
        check("redir_count", q_count0, 1);
        check("redir_byte0", q_data0[7:0], 8'h4A);
        tick();

        // illegal pop 4 with 2 valid
        check("ill_count_before", q_count0, 2);
        pop_cnt0 = 3'd4;
        #1;
        check("ill_err_1", pop_err0, 1);
        check("ill_en_low", rom_en0, 0);
        tick();
        check("ill_err_2", pop_err0, 1);
        check("ill_count_mid", q_count0, 3);
        tick();
        pop_cnt0 = 3'd0;
        #1;
        check("ill_count_after", q_count0, 3);
        check("ill_err_clear", pop_err0, 0);
        check("ill_data", q_data0, 48'h000000484B4A);
        check("ill_ip", q_ip0, 16'h0010);

        // wide-fetch instance: redirect near the top of the 1 MB space
        flush1 = 1'b1; flush_cs1 = 16'hFFFF; flush_ip1 = 16'hFFFE;
        #1;
        check("w_flush_en_low", rom_en1, 0);
        tick();
        flush1 = 1'b0;
        #1;
        check("w_addr0", rom_addr1, 20'h0FFEE);
        check("w_en0", rom_en1, 1);
        check("w_ip0", q_ip1, 16'hFFFE);
        check("w_count0", q_count1, 0);
        tick();
        check("w_addr1", rom_addr1, 20'h0FFF0);
        check("w_en1", rom_en1, 1);
        tick();
        check("w_count2", q_count1, 2);
        check("w_data2", q_data1[15:0], 16'hB5B4);
        pop_cnt1 = 3'd1;
        tick();
        check("w_ip_ffff", q_ip1, 16'hFFFF);
        check("w_count3", q_count1, 3);
        tick();
        pop_cnt1 = 3'd0;
        #1;
        check("w_ip_wrap", q_ip1, 16'h0000);
        check("w_count4", q_count1, 4);
        check("w_byte0", q_data1[7:0], 8'hAA);
        tick();

        // count 6 with 2 in flight: pop 2 and push 2 together
        check("w_guard_count", q_count1, 6);
        check("w_guard_en", rom_en1, 0);
        pop_cnt1 = 3'd2;
        #1;
        check("w_pp_err", pop_err1, 0);
        tick();
        pop_cnt1 = 3'd0;
        #1;
        check("w_pp_count", q_count1, 6);
        check("w_pp_data", q_data1, 48'hADACAFAEA9A8);
        check("w_pp_en", rom_en1, 1);
        tick();
        check("w_pp_guard", rom_en1, 0);
        tick();
        check("w_full_count", q_count1, 8);
        check("w_full_en", rom_en1, 0);
        check("w_full_data", q_data1, 48'hADACAFAEA9A8);

        // pop beyond PEEK is illegal even though 8 bytes are valid
        pop_cnt1 = 3'd7;
        #1;
        check("w_peek_err", pop_err1, 1);
        tick();
        pop_cnt1 = 3'd0;
        #1;
        check("w_peek_count", q_count1, 8);
        check("w_peek_err_clear", pop_err1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
